// File: rtl/stock_cmd_scheduler.sv
// rtl/stock_cmd_scheduler.sv - host command FIFO and one-at-a-time issuer for stock_weight units
module stock_cmd_scheduler #(
  parameter int NUM_STOCKS     = 4,
  parameter int IDX_W          = 2,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic [IDX_W-1:0]         host_stock,
  input  logic [47:0]              host_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDX_W-1:0]         resp_stock,
  output logic [1:0]               resp_status,
  output logic [39:0]              resp_data,
  output logic                     sw_data_valid,
  output logic [NUM_STOCKS-1:0]    sw_stock_selected,
  output logic [47:0]              sw_data,
  input  logic [NUM_STOCKS-1:0]    sw_data_ready,
  input  logic [NUM_STOCKS*40-1:0] sw_out,
  output logic                     busy
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int ENTRY_W = IDX_W + 48;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_TIMEOUT   = 2'b01;
  localparam logic [1:0] ST_BAD_CMD   = 2'b10;
  localparam logic [1:0] ST_BAD_STOCK = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t state, state_n;

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               fifo_empty, fifo_full, push, pop;

  logic [ENTRY_W-1:0] head;
  logic [IDX_W-1:0]   head_stock;
  logic [47:0]        head_data;
  logic [7:0]         head_cmd;
  logic               stock_ok, cmd_ok;

  // Selected unit of the in-flight command and its WAIT budget
  logic [IDX_W-1:0]   sel_idx, sel_idx_n;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_n;
  logic               tmo_last, sel_ready;
  logic [39:0]        unit_out [NUM_STOCKS];
  logic [39:0]        sel_out;

  logic                  resp_valid_n, sw_data_valid_n;
  logic [IDX_W-1:0]      resp_stock_n;
  logic [1:0]            resp_status_n;
  logic [39:0]           resp_data_n;
  logic [NUM_STOCKS-1:0] sw_sel_n;
  logic [47:0]           sw_data_n;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign host_ready = !fifo_full;
  assign push       = host_valid && !fifo_full;
  assign pop        = (state == S_IDLE) && !fifo_empty;

  assign head       = fifo_mem[rd_ptr];
  assign head_stock = head[ENTRY_W-1:48];
  assign head_data  = head[47:0];
  assign head_cmd   = head_data[47:40];
  assign stock_ok   = (32'(head_stock) < 32'(NUM_STOCKS));
  assign cmd_ok     = (head_cmd >= 8'h0A) && (head_cmd <= 8'h0E);

  for (genvar g = 0; g < NUM_STOCKS; g++) begin : g_unit_out
    assign unit_out[g] = sw_out[g*40 +: 40];
  end

  assign sel_out   = unit_out[sel_idx];
  assign sel_ready = sw_data_ready[sel_idx];
  assign tmo_last  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign busy      = (state != S_IDLE) || !fifo_empty;

  // FIFO data array; entries are not reset, only the pointers are
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {host_stock, host_data};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // State register plus every registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      sel_idx           <= '0;
      tmo_cnt           <= '0;
      resp_valid        <= 1'b0;
      resp_stock        <= '0;
      resp_status       <= '0;
      resp_data         <= '0;
      sw_data_valid     <= 1'b0;
      sw_stock_selected <= '0;
      sw_data           <= '0;
    end else begin
      state             <= state_n;
      sel_idx           <= sel_idx_n;
      tmo_cnt           <= tmo_cnt_n;
      resp_valid        <= resp_valid_n;
      resp_stock        <= resp_stock_n;
      resp_status       <= resp_status_n;
      resp_data         <= resp_data_n;
      sw_data_valid     <= sw_data_valid_n;
      sw_stock_selected <= sw_sel_n;
      sw_data           <= sw_data_n;
    end
  end

  // Next-state: rejects skip the bus and go straight to RESP
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_n = (stock_ok && cmd_ok) ? S_ISSUE : S_RESP;
      S_ISSUE: state_n = S_WAIT;
      S_WAIT:  if (sel_ready || tmo_last) state_n = S_RESP;
      S_RESP:  if (resp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; anything not touched holds
  always_comb begin
    resp_valid_n    = resp_valid;
    resp_stock_n    = resp_stock;
    resp_status_n   = resp_status;
    resp_data_n     = resp_data;
    sw_data_valid_n = sw_data_valid;
    sw_sel_n        = sw_stock_selected;
    sw_data_n       = sw_data;
    sel_idx_n       = sel_idx;
    tmo_cnt_n       = tmo_cnt;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (!stock_ok) begin
            resp_valid_n  = 1'b1;
            resp_stock_n  = head_stock;
            resp_status_n = ST_BAD_STOCK;
            resp_data_n   = '0;
          end else if (!cmd_ok) begin
            resp_valid_n  = 1'b1;
            resp_stock_n  = head_stock;
            resp_status_n = ST_BAD_CMD;
            resp_data_n   = '0;
          end else begin
            sw_data_valid_n = 1'b1;
            sw_sel_n        = NUM_STOCKS'(1) << head_stock;
            sw_data_n       = head_data;
            sel_idx_n       = head_stock;
          end
        end
      end
      S_ISSUE: begin
        sw_data_valid_n = 1'b0;
        sw_sel_n        = '0;
        tmo_cnt_n       = '0;
      end
      S_WAIT: begin
        if (sel_ready) begin
          resp_valid_n  = 1'b1;
          resp_stock_n  = sel_idx;
          resp_status_n = ST_OK;
          resp_data_n   = sel_out;
        end else if (tmo_last) begin
          resp_valid_n  = 1'b1;
          resp_stock_n  = sel_idx;
          resp_status_n = ST_TIMEOUT;
          resp_data_n   = '0;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) resp_valid_n = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stock_cmd_scheduler.sv
// tb/tb_stock_cmd_scheduler.sv - directed scoreboard bench for stock_cmd_scheduler
module tb_stock_cmd_scheduler;

  localparam int NS  = 4;
  localparam int TMO = 16;
  localparam logic [39:0] U0 = 40'hAAAAAAAA00;
  localparam logic [39:0] U1 = 40'hCCCCCCCCCC;
  localparam logic [39:0] U2 = 40'h3333333333;
  localparam logic [39:0] U3 = 40'h4444444444;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         host_valid, host_ready, resp_valid, resp_ready, sw_data_valid, busy;
  logic [1:0]   host_stock, resp_stock, resp_status;
  logic [47:0]  host_data, sw_data;
  logic [39:0]  resp_data;
  logic [3:0]   sw_stock_selected, sw_data_ready;
  logic [159:0] sw_out;

  logic         h3_valid, h3_ready, r3_valid, r3_ready, s3_dv, busy3;
  logic [1:0]   h3_stock, r3_stock, r3_status;
  logic [47:0]  h3_data, s3_data;
  logic [39:0]  r3_data;
  logic [2:0]   s3_sel, s3_ready;
  logic [119:0] s3_out;

  stock_cmd_scheduler #(.NUM_STOCKS(NS), .IDX_W(2), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .host_valid(host_valid), .host_ready(host_ready),
    .host_stock(host_stock), .host_data(host_data), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_stock(resp_stock), .resp_status(resp_status),
    .resp_data(resp_data), .sw_data_valid(sw_data_valid), .sw_stock_selected(sw_stock_selected),
    .sw_data(sw_data), .sw_data_ready(sw_data_ready), .sw_out(sw_out), .busy(busy));

  stock_cmd_scheduler #(.NUM_STOCKS(3), .IDX_W(2), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut3 (
    .clk(clk), .rst(rst), .host_valid(h3_valid), .host_ready(h3_ready),
    .host_stock(h3_stock), .host_data(h3_data), .resp_valid(r3_valid),
    .resp_ready(r3_ready), .resp_stock(r3_stock), .resp_status(r3_status),
    .resp_data(r3_data), .sw_data_valid(s3_dv), .sw_stock_selected(s3_sel),
    .sw_data(s3_data), .sw_data_ready(s3_ready), .sw_out(s3_out), .busy(busy3));

  int n_assert = 0;
  int n_fail   = 0;
  int dv_pulses = 0;
  int resp_count = 0;
  logic [43:0] sb [$];

  logic [3:0] model_en, model_ready, extra_ready, pend_sel;
  logic       pend, prev_dv;

  assign sw_out        = {U3, U2, U1, U0};
  assign sw_data_ready = model_ready | extra_ready;
  assign s3_ready      = 3'b000;
  assign s3_out        = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] unit_val(input logic [1:0] i);
    case (i)
      2'd0: return U0;
      2'd1: return U1;
      2'd2: return U2;
      default: return U3;
    endcase
  endfunction

  function automatic logic [43:0] exp_resp(input logic [1:0] stk, input logic [7:0] cmd,
                                           input int ns, input logic [3:0] en);
    if (int'(stk) >= ns) return {stk, 2'b11, 40'd0};
    if (cmd < 8'h0A || cmd > 8'h0E) return {stk, 2'b10, 40'd0};
    if (en[stk]) return {stk, 2'b00, unit_val(stk)};
    return {stk, 2'b01, 40'd0};
  endfunction

  // Unit model: a selected, enabled unit answers with a one-cycle ready in the first WAIT cycle
  always @(negedge clk) begin
    model_ready = 4'b0000;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        model_ready = pend_sel & model_en;
        pend = 1'b0;
      end
      if (sw_data_valid) begin
        pend = 1'b1;
        pend_sel = sw_stock_selected;
      end
    end
  end

  // Response monitor: strobe width, strobe count and scoreboard comparison at each handshake
  always @(negedge clk) begin
    int n_pending;
    logic [43:0] e;
    #1;
    if (rst) begin
      prev_dv = 1'b0;
    end else begin
      if (sw_data_valid) begin
        check("dv_single_cycle", 64'(prev_dv), 64'd0);
        dv_pulses++;
      end
      prev_dv = sw_data_valid;
      if (resp_valid && resp_ready) begin
        resp_count++;
        n_pending = sb.size();
        check("resp_expected", 64'(n_pending > 0), 64'd1);
        if (n_pending > 0) begin
          e = sb.pop_front();
          check("resp_stock", 64'(resp_stock), 64'(e[43:42]));
          check("resp_status", 64'(resp_status), 64'(e[41:40]));
          check("resp_data", 64'(resp_data), 64'(e[39:0]));
        end
      end
    end
  end

  task automatic push_cmd(input logic [1:0] stk, input logic [7:0] cmd, input logic [39:0] pl,
                          input bit expect_resp);
    bit ok;
    if (expect_resp) sb.push_back(exp_resp(stk, cmd, NS, model_en));
    host_stock = stk;
    host_data  = {cmd, pl};
    host_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (host_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("push_accept", 64'(ok), 64'd1);
    @(posedge clk);
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    int lat, rc, pc;
    bit seen_dv3, got3;
    rst = 1'b1;
    host_valid = 1'b0; host_stock = '0; host_data = '0; resp_ready = 1'b0;
    h3_valid = 1'b0; h3_stock = '0; h3_data = '0; r3_ready = 1'b0;
    model_en = 4'hF; extra_ready = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_outputs", {resp_valid, resp_stock, resp_status, resp_data, sw_data_valid, sw_stock_selected, sw_data}, 64'd0);
    check("rst_sw_data", 64'(sw_data), 64'd0);
    check("rst_host_ready", 64'(host_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst3_ready_busy", {h3_ready, busy3, r3_valid}, 64'b100);

    // OK path with latency and strobe shape
    resp_ready = 1'b1;
    push_cmd(2'd1, 8'h0A, 40'h0102030405, 1'b1);
    @(negedge clk);
    check("ok_issue_dv", 64'(sw_data_valid), 64'd1);
    check("ok_issue_sel", 64'(sw_stock_selected), 64'b0010);
    check("ok_issue_data", 64'(sw_data), 64'h0A0102030405);
    @(negedge clk);
    check("ok_wait_dv", {sw_data_valid, sw_stock_selected, resp_valid}, 64'd0);
    check("ok_wait_data_held", 64'(sw_data), 64'h0A0102030405);
    @(negedge clk);
    check("ok_resp_latency", 64'(resp_valid), 64'd1);
    @(negedge clk);
    check("ok_resp_done", {resp_valid, busy}, 64'd0);

    // Timeout with a stray ready from a non-selected unit, then a late ready
    model_en = 4'b1011;
    push_cmd(2'd2, 8'h0C, 40'h1111111111, 1'b1);
    lat = 0;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      extra_ready = (t == 5) ? 4'b0001 : 4'b0000;
      if (resp_valid) begin
        lat = t;
        break;
      end
    end
    extra_ready = 4'b0000;
    check("timeout_latency", 64'(lat), 64'(TMO + 2));
    @(negedge clk);
    rc = resp_count;
    extra_ready = 4'b0100;
    @(negedge clk);
    extra_ready = 4'b0000;
    repeat (5) @(negedge clk);
    check("late_ready_ignored", 64'(resp_count), 64'(rc));
    check("late_ready_idle", {resp_valid, busy}, 64'd0);

    // Rejects and the upper valid command boundary
    pc = dv_pulses;
    push_cmd(2'd0, 8'h0F, 40'h0, 1'b1);
    push_cmd(2'd3, 8'h09, 40'h0, 1'b1);
    push_cmd(2'd3, 8'h0E, 40'h77, 1'b1);
    wait_idle(100);
    check("reject_no_strobe", 64'(dv_pulses - pc), 64'd1);

    // BAD_STOCK beats BAD_CMD on a three-unit instance
    r3_ready = 1'b1;
    h3_stock = 2'd3; h3_data = {8'h07, 40'h55}; h3_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    h3_valid = 1'b0;
    seen_dv3 = 1'b0; got3 = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (s3_dv) seen_dv3 = 1'b1;
      if (r3_valid) begin
        got3 = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("bad_stock_resp", 64'(got3), 64'd1);
    check("bad_stock_fields", {r3_stock, r3_status, r3_data}, {2'd3, 2'b11, 40'd0});
    check("bad_stock_no_strobe", 64'(seen_dv3), 64'd0);

    // FIFO full under backpressure, then response hold
    model_en = 4'hF;
    resp_ready = 1'b0;
    pc = dv_pulses;
    push_cmd(2'd0, 8'h0A, 40'h1, 1'b1);
    push_cmd(2'd1, 8'h0B, 40'h2, 1'b1);
    push_cmd(2'd3, 8'h0F, 40'h3, 1'b1);
    push_cmd(2'd2, 8'h0D, 40'h4, 1'b1);
    push_cmd(2'd3, 8'h0E, 40'h5, 1'b1);
    check("fifo_full", 64'(host_ready), 64'd0);
    host_stock = 2'd1; host_data = {8'h0B, 40'h6}; host_valid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("resp_hold", {host_ready, resp_valid, resp_stock, resp_status, resp_data, sw_data_valid},
            {1'b0, 1'b1, 2'd0, 2'b00, U0, 1'b0});
    end
    host_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("resp_drop_edge", 64'(resp_valid), 64'd0);
    @(negedge clk);
    resp_ready = 1'b0;
    check("no_issue_on_drop", 64'(sw_data_valid), 64'd0);
    @(negedge clk);
    check("issue_after_idle", 64'(sw_data_valid), 64'd1);
    resp_ready = 1'b1;
    wait_idle(200);
    check("full_strobe_count", 64'(dv_pulses - pc), 64'd4);

    // Reset in WAIT with two commands queued
    model_en = 4'h0;
    push_cmd(2'd0, 8'h0A, 40'h8, 1'b0);
    push_cmd(2'd1, 8'h0A, 40'h9, 1'b0);
    push_cmd(2'd2, 8'h0A, 40'hA, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_outputs", {resp_valid, resp_stock, resp_status, resp_data, sw_data_valid, sw_stock_selected}, 64'd0);
    check("mid_rst_sw_data", 64'(sw_data), 64'd0);
    check("mid_rst_ready_busy", {host_ready, busy}, 64'b10);
    rc = resp_count;
    pc = dv_pulses;
    repeat (30) @(negedge clk);
    check("mid_rst_no_resp", 64'(resp_count), 64'(rc));
    check("mid_rst_no_strobe", 64'(dv_pulses), 64'(pc));
    check("mid_rst_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
